// File: rtl/booth_seq_divider_if.sv
// Handshake and data bundle for booth_seq_divider.
// The master side issues operands and start; the slave side returns status and results.
interface booth_seq_divider_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   overflow;
    logic                   div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/booth_seq_divider.sv
// Sequential signed divider: restoring radix-2 on magnitudes, one quotient bit per clock,
// followed by a single sign-fixup cycle that registers the results and pulses done.
module booth_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    booth_seq_divider_if.slave bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW) + 1;
    localparam logic [DW-1:0] POS_LIM = DW'((1 << (WIDTH - 1)) - 1);
    localparam logic [DW-1:0] NEG_LIM = DW'(1 << (WIDTH - 1));

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CW-1:0]      cnt_reg;
    logic               sign_dvd_reg;
    logic               sign_dsr_reg;
    logic               zero_reg;
    logic [DW-1:0]      dvd_mag_reg;
    logic [WIDTH-1:0]   dsr_mag_reg;
    logic [WIDTH-1:0]   dvd_low_reg;
    logic [WIDTH:0]     rem_reg;
    logic [DW-1:0]      q_mag_reg;

    logic               done_reg;
    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic               overflow_reg;
    logic               div_by_zero_reg;

    logic               accept;
    logic [WIDTH+1:0]   rem_shift;
    logic [WIDTH+1:0]   trial;
    logic               trial_ok;
    logic               q_neg;
    logic [WIDTH-1:0]   q_low;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               ovf_fix;

    assign accept = (state_reg == IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.divisor == '0) ? FIX : ITER;
                end
            end
            ITER: begin
                if (cnt_reg == CW'(DW - 1)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The extra top bit of the trial difference is the borrow: set means restore.
    always_comb begin
        rem_shift = {rem_reg, dvd_mag_reg[DW-1]};
        trial     = rem_shift - {2'b00, dsr_mag_reg};
        trial_ok  = ~trial[WIDTH+1];
    end

    // Low bits of a negated magnitude equal the negation of its low bits, so only
    // the overflow test needs the full-width quotient magnitude.
    always_comb begin
        q_neg   = sign_dvd_reg ^ sign_dsr_reg;
        q_low   = q_mag_reg[WIDTH-1:0];
        q_fix   = q_neg ? -q_low : q_low;
        r_fix   = sign_dvd_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
        ovf_fix = q_neg ? (q_mag_reg > NEG_LIM) : (q_mag_reg > POS_LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            sign_dvd_reg <= 1'b0;
            sign_dsr_reg <= 1'b0;
            zero_reg     <= 1'b0;
            dvd_mag_reg  <= '0;
            dsr_mag_reg  <= '0;
            dvd_low_reg  <= '0;
            rem_reg      <= '0;
            q_mag_reg    <= '0;
        end else if (accept) begin
            cnt_reg      <= '0;
            sign_dvd_reg <= bus.dividend[DW-1];
            sign_dsr_reg <= bus.divisor[WIDTH-1];
            zero_reg     <= (bus.divisor == '0);
            dvd_mag_reg  <= bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
            dsr_mag_reg  <= bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
            dvd_low_reg  <= bus.dividend[WIDTH-1:0];
            rem_reg      <= '0;
            q_mag_reg    <= '0;
        end else if (state_reg == ITER) begin
            cnt_reg     <= cnt_reg + 1'b1;
            dvd_mag_reg <= {dvd_mag_reg[DW-2:0], 1'b0};
            rem_reg     <= trial_ok ? trial[WIDTH:0] : rem_shift[WIDTH:0];
            q_mag_reg   <= {q_mag_reg[DW-2:0], trial_ok};
        end else if (state_reg == FIX) begin
            cnt_reg <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_reg        <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            overflow_reg    <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == FIX);
            if (state_reg == FIX) begin
                if (zero_reg) begin
                    quotient_reg    <= '1;
                    remainder_reg   <= dvd_low_reg;
                    overflow_reg    <= 1'b0;
                    div_by_zero_reg <= 1'b1;
                end else begin
                    quotient_reg    <= q_fix;
                    remainder_reg   <= r_fix;
                    overflow_reg    <= ovf_fix;
                    div_by_zero_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.div_by_zero = div_by_zero_reg;
endmodule

// File: doc/booth_seq_divider.md
Name: booth_seq_divider

Overview:
Sequential signed two's-complement divider; the inverse of the combinational Booth multiplier in the datapath. Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and returns a WIDTH-bit quotient and a WIDTH-bit remainder. The block uses radix-2 restoring iterations on operand magnitudes, one quotient bit per clock, and a start/done handshake. Division truncates toward zero.

Parameters:
WIDTH, 4, divisor/quotient/remainder width; dividend is 2*WIDTH bits; WIDTH >= 2

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only when busy=0
dividend  in  2*WIDTH  signed dividend, captured on accepted start
divisor  in  WIDTH  signed divisor, captured on accepted start
busy  out  1  high from cycle after accepted start through FIX cycle
done  out  1  one-cycle pulse, results valid
quotient  out  WIDTH  signed quotient (low WIDTH bits of true quotient)
remainder  out  WIDTH  signed remainder, sign follows dividend
overflow  out  1  true quotient not representable in signed WIDTH bits
div_by_zero  out  1  divisor was zero

Behaviour:
- Reset (async, any state incl. mid-division): state=IDLE; busy=0, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0; iteration counter=0.
- States: IDLE, ITER, FIX.
- IDLE: start=1 -> capture operands, signs (dividend MSB, divisor MSB), magnitudes (|dividend| as 2W-bit unsigned, |divisor| as W-bit unsigned; most-negative values map to 2^(2W-1) / 2^(W-1) exactly). Next state ITER, or FIX directly if divisor==0.
- ITER: exactly 2*WIDTH cycles. Partial remainder R (WIDTH+1 bits) shifts left, taking the next dividend magnitude bit MSB-first. Trial subtract R-|divisor|; if non-negative keep and q bit=1, else restore and q bit=0. A 2W-bit quotient magnitude register accumulates the bits. After the last iteration go to FIX.
- FIX (1 cycle): apply signs. Quotient negated if signs differ. Remainder negated if dividend negative. Register outputs at the end of FIX, pulse done, return to IDLE.
- Overflow: overflow=1 if the quotient magnitude exceeds 2^(W-1)-1 (positive result) or 2^(W-1) (negative result). quotient still equals the low WIDTH bits of the signed true quotient. remainder is exact.
- Divide by zero: div_by_zero=1, overflow=0, quotient=all ones, remainder=dividend[WIDTH-1:0].
- Timing: cycle 0 = cycle with start=1 accepted. Normal: busy=1 in cycles 1..2W+1, done=1 in cycle 2W+2 (WIDTH=4: cycle 10). Divide by zero: busy=1 in cycle 1, done=1 in cycle 2.
- done is high for exactly one cycle. busy=0 in the done cycle, and start in that cycle is accepted.
- start while busy=1 is ignored. It is not queued and does not disturb the operation in flight.
- Outputs hold their last values until the next FIX overwrites them. Flags clear/set only at FIX.
- Operand inputs may change freely after the accept cycle.

Test Plan:
- WIDTH=4, dividend=35, divisor=5 -> done in cycle 10; quotient=4'b0111, remainder=0, overflow=0, div_by_zero=0; busy high cycles 1-9.
- dividend=-37 (8'hDB), divisor=5 -> quotient=4'b1001 (-7), remainder=4'b1110 (-2). Then dividend=37, divisor=-5 -> quotient=4'b1001, remainder=4'b0010.
- dividend=-40, divisor=5 -> quotient=4'b1000, overflow=0. Then dividend=40, divisor=5 -> quotient=4'b1000, overflow=1. Then dividend=-128, divisor=-1 -> overflow=1, quotient=4'b0000, remainder=0.
- dividend=8'h5A, divisor=0 -> done in cycle 2, div_by_zero=1, quotient=4'b1111, remainder=4'b1010, overflow=0.
- Issue 35/5, then pulse start with 100/3 in cycle 4 -> ignored; result 7 R0 in cycle 10. Issue a new start in cycle 10 (done cycle) -> accepted, done in cycle 20.
- Start 35/5, assert rst in cycle 5 -> all outputs 0 immediately, state IDLE. Release rst, start -37/5 -> correct -7 R-2 with normal latency.
